// File: rtl/hs_fifo.sv
// hs_fifo: DEPTH-entry valid/ready FIFO with occupancy count and synchronous flush.
// Build option HS_FIFO_PASS_EN: a full FIFO also accepts a push in a cycle where the head
// is popped, which adds a combinational ready_out -> ready_in path. Without the macro,
// ready_in is decoded from registers only.
module hs_fifo #(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_WD  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               valid_in,
    input  logic [DATA_WD-1:0] data_in,
    output logic               ready_in,
    output logic               valid_out,
    output logic [DATA_WD-1:0] data_out,
    input  logic               ready_out,
    output logic [CNT_WD-1:0]  count
);

    localparam int unsigned       PTR_WD   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WD-1:0] PTR_LAST = PTR_WD'(DEPTH - 1);
    localparam logic [CNT_WD-1:0] CNT_FULL = CNT_WD'(DEPTH);

    logic [DATA_WD-1:0] mem_q [DEPTH];
    logic [DATA_WD-1:0] mem_d [DEPTH];
    logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WD-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WD-1:0]  count_q, count_d;
    logic               fire_in, fire_out;

    // Handshake decode and head-of-queue outputs, straight from the registers.
    always_comb begin
`ifdef HS_FIFO_PASS_EN
        ready_in = (count_q != CNT_FULL) | ready_out;
`else
        ready_in = (count_q != CNT_FULL);
`endif
        valid_out = (count_q != '0);
        data_out  = mem_q[rd_ptr_q];
        count     = count_q;
        fire_in   = valid_in & ready_in;
        fire_out  = valid_out & ready_out;
    end

    // Next-state: write at wr_ptr, advance pointers with wrap, track occupancy; flush wins.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fire_in) begin
                mem_d[wr_ptr_q] = data_in;
                wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_WD'(1);
            end
            if (fire_out) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_WD'(1);
            end
            if (fire_in && !fire_out) begin
                count_d = count_q + CNT_WD'(1);
            end else if (!fire_in && fire_out) begin
                count_d = count_q - CNT_WD'(1);
            end
        end
    end

    // State registers; reset drops every entry at once and clears storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_hs_fifo.sv
// tb_hs_fifo: directed tests on a DEPTH=4 instance and a random run on a DEPTH=3 instance,
// both checked every cycle against queue-based scoreboards.
module tb_hs_fifo;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: DEPTH=4
    logic          a_flush, a_vin, a_rdy_in, a_vout, a_rout;
    logic [DW-1:0] a_din, a_dout;
    logic [2:0]    a_cnt;
    // Instance B: DEPTH=3
    logic          b_vin, b_rdy_in, b_vout, b_rout;
    logic [DW-1:0] b_din, b_dout;
    logic [1:0]    b_cnt;

    hs_fifo #(.DATA_WD(DW), .DEPTH(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (a_flush),
        .valid_in  (a_vin),
        .data_in   (a_din),
        .ready_in  (a_rdy_in),
        .valid_out (a_vout),
        .data_out  (a_dout),
        .ready_out (a_rout),
        .count     (a_cnt)
    );

    hs_fifo #(.DATA_WD(DW), .DEPTH(3)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .valid_in  (b_vin),
        .data_in   (b_din),
        .ready_in  (b_rdy_in),
        .valid_out (b_vout),
        .data_out  (b_dout),
        .ready_out (b_rout),
        .count     (b_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboards: payloads pushed on modelled acceptance, popped on modelled transfer.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic          b_took = 1'b0;

    // Model of A, evaluated mid-cycle with inputs stable.
    always @(negedge clk) begin
        logic er;
        if (!rst) begin
            check_val("a_count", 32'(a_cnt), 32'(qa.size()));
            check_val("a_valid", 32'(a_vout), 32'(qa.size() != 0));
            if (qa.size() != 0) check_val("a_data", 32'(a_dout), 32'(qa[0]));
            er = (qa.size() != 4);
`ifdef HS_FIFO_PASS_EN
            er = er | a_rout;
`endif
            check_val("a_ready_in", 32'(a_rdy_in), 32'(er));
            if (a_flush) begin
                qa.delete();
            end else begin
                if (qa.size() != 0 && a_rout) void'(qa.pop_front());
                if (a_vin && er) qa.push_back(a_din);
            end
        end
    end

    // Model of B, plus the bound on occupancy.
    always @(negedge clk) begin
        logic er;
        if (!rst) begin
            check_val("b_count", 32'(b_cnt), 32'(qb.size()));
            check_val("b_cnt_max", 32'(b_cnt <= 2'd3 && qb.size() <= 3), 32'd1);
            check_val("b_valid", 32'(b_vout), 32'(qb.size() != 0));
            if (qb.size() != 0) check_val("b_data", 32'(b_dout), 32'(qb[0]));
            er = (qb.size() != 3);
`ifdef HS_FIFO_PASS_EN
            er = er | b_rout;
`endif
            check_val("b_ready_in", 32'(b_rdy_in), 32'(er));
            b_took = b_vin && er;
            if (qb.size() != 0 && b_rout) void'(qb.pop_front());
            if (b_vin && er) qb.push_back(b_din);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [DW-1:0] v);
        a_vin = 1'b1;
        a_din = v;
        step();
        a_vin = 1'b0;
    endtask

    logic [DW-1:0] fill_vals [4];

    initial begin
        fill_vals[0] = 8'h11; fill_vals[1] = 8'h22; fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;
        rst = 1'b1;
        a_flush = 1'b0; a_vin = 1'b0; a_din = '0; a_rout = 1'b0;
        b_vin = 1'b0; b_din = '0; b_rout = 1'b0;

        // Reset values
        #7;
        check_val("rst_valid", 32'(a_vout), 32'd0);
        check_val("rst_ready", 32'(a_rdy_in), 32'd1);
        check_val("rst_count", 32'(a_cnt), 32'd0);
        check_val("rst_data", 32'(a_dout), 32'd0);
        #5;
        rst = 1'b0;
        step();

        // Fill with back-pressure, then a refused fifth push
        for (int i = 0; i < 4; i++) push_a(fill_vals[i]);
        check_val("full_count", 32'(a_cnt), 32'd4);
        check_val("full_ready", 32'(a_rdy_in), 32'd0);
        a_vin = 1'b1;
        a_din = 8'h55;
        step();
        step();
        check_val("held_count", 32'(a_cnt), 32'd4);
        a_vin  = 1'b0;
        a_rout = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("drain_data", 32'(a_dout), 32'(fill_vals[i]));
            step();
        end
        check_val("drain_count", 32'(a_cnt), 32'd0);

        // Streaming at one transfer per cycle
        a_vin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a_din = DW'(8'h80 + i);
            step();
            check_val("stream_count", 32'(a_cnt), 32'd1);
            check_val("stream_data", 32'(a_dout), 32'(8'h80 + i));
        end
        a_vin = 1'b0;
        step();

        // Full with simultaneous push and pop
        a_rout = 1'b0;
        for (int i = 0; i < 4; i++) push_a(DW'(8'h60 + i));
        a_vin  = 1'b1;
        a_din  = 8'h64;
        a_rout = 1'b1;
        step();
        a_vin = 1'b0;
`ifdef HS_FIFO_PASS_EN
        check_val("full_pop_count", 32'(a_cnt), 32'd4);
`else
        check_val("full_pop_count", 32'(a_cnt), 32'd3);
`endif
        for (int i = 0; i < 4; i++) step();
        check_val("full_pop_empty", 32'(a_cnt), 32'd0);

        // Flush at count=3 with concurrent push and pop
        a_rout = 1'b0;
        for (int i = 0; i < 3; i++) push_a(DW'(8'h70 + i));
        a_flush = 1'b1;
        a_vin   = 1'b1;
        a_din   = 8'h7F;
        a_rout  = 1'b1;
        step();
        a_flush = 1'b0;
        a_vin   = 1'b0;
        a_rout  = 1'b0;
        check_val("flush_count", 32'(a_cnt), 32'd0);
        check_val("flush_valid", 32'(a_vout), 32'd0);
        push_a(8'hAA);
        check_val("post_flush_valid", 32'(a_vout), 32'd1);
        check_val("post_flush_data", 32'(a_dout), 32'hAA);
        a_rout = 1'b1;
        step();
        a_rout = 1'b0;

        // Asynchronous reset mid-burst at count=3
        for (int i = 0; i < 3; i++) push_a(DW'(8'h90 + i));
        check_val("pre_rst_count", 32'(a_cnt), 32'd3);
        rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        check_val("async_rst_count", 32'(a_cnt), 32'd0);
        check_val("async_rst_valid", 32'(a_vout), 32'd0);
        #1;
        rst = 1'b0;
        step();

        // Random traffic on the DEPTH=3 instance; held data stays put until accepted
        for (int i = 0; i < 1000; i++) begin
            if (!b_vin || b_took) begin
                b_vin = 1'($urandom_range(0, 1));
                b_din = DW'($urandom);
            end
            b_rout = 1'($urandom_range(0, 1));
            step();
        end
        b_vin  = 1'b0;
        b_rout = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_val("b_final_count", 32'(b_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
